pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the instruction-index width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, the index loaded on reset.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, the return-stack entries (min 2).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port stall  input  1  holds all state when high.
REQ-007 SHALL have port load_en  input  1  jump/branch-taken request.
REQ-008 SHALL have port load_addr  input  WIDTH  jump/branch/call target.
REQ-009 SHALL have port call_en  input  1  call request: push return index, jump to load_addr.
REQ-010 SHALL have port ret_en  input  1  return request: pop the stack into the PC.
REQ-011 SHALL have port pc_out  output  WIDTH  current instruction index, registered.
REQ-012 SHALL have port pc_next  output  WIDTH  combinational index that pc_out takes at the next edge.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse: the increment rolled over from all-ones to 0.
REQ-014 SHALL have port stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-015 SHALL have port stack_empty  output  1  stack holds 0 entries.
REQ-016 SHALL have port stack_err  output  1  registered one-cycle pulse on a push to a full stack or a pop from an empty stack.

Function
REQ-017 SHALL apply per-edge priority rst > stall > ret_en > call_en > load_en > increment.
REQ-018 SHALL set pc_out to pc_out+1 modulo 2^WIDTH when no request is active.
REQ-019 SHALL pulse wrap for one cycle only when the increment takes pc_out from 2^WIDTH-1 to 0; load, call and ret never set wrap.
REQ-020 SHALL set pc_out to load_addr on load_en and leave the stack unchanged.
REQ-021 SHALL, on call_en with stack not full, push pc_out+1 (mod 2^WIDTH) and set pc_out to load_addr.
REQ-022 SHALL, on call_en with stack full, set pc_out to load_addr, discard the push, keep the stack contents, and pulse stack_err.
REQ-023 SHALL, on ret_en with stack not empty, set pc_out to the top entry and pop it (LIFO).
REQ-024 SHALL, on ret_en with stack empty, perform a normal increment and pulse stack_err.
REQ-025 SHALL, when stall is high, hold pc_out, the stack and the occupancy; wrap and stack_err SHALL read 0 that cycle.
REQ-026 SHALL drive pc_next to the value selected by REQ-017..REQ-025 and show pc_out while stalled.
REQ-027 SHALL derive stack_full and stack_empty combinationally from the registered occupancy count.
REQ-028 SHALL give zero-cycle latency: a request sampled at edge N is visible on pc_out right after edge N.

Reset
REQ-029 SHALL, on rst at a rising edge, set pc_out=RESET_VEC, wrap=0, stack_err=0 and occupancy=0 (stack_empty=1, stack_full=0), overriding stall and all requests.
REQ-030 SHALL NOT require the stack entry storage to be reset; entries are invalid when the stack is empty.
REQ-031 SHALL apply rst received mid-call-chain so that the next ret_en after reset is an empty-stack pop.

Configuration
REQ-032 SHALL compile the return stack only when the macro PC_SEQUENCER_CALL_STACK_EN is defined.
REQ-033 SHALL, without PC_SEQUENCER_CALL_STACK_EN, keep all ports, ignore call_en and ret_en (increment or load applies), and tie stack_full=0, stack_empty=1, stack_err=0.

Verification
REQ-034 SHALL check reset: rst=1 with load_en=1, load_addr=0x40, RESET_VEC=0x10 -> pc_out=0x10, stack_empty=1; free-running -> 0x11, 0x12.
REQ-035 SHALL check wrap: pc_out=0xFE -> 0xFF -> 0x00 with wrap=1 for that one cycle only; stall at 0xFF holds 0xFF with wrap=0.
REQ-036 SHALL check call/ret: pc_out=0x05, call_en with load_addr=0x80 -> 0x80; run to 0x82, ret_en -> pc_out=0x06, stack_empty=1.
REQ-037 SHALL check overflow: five nested calls with STACK_DEPTH=4 -> fifth sets stack_err=1 and still jumps; four rets return the first four pushed values in reverse order.
REQ-038 SHALL check underflow/priority: ret_en on empty at 0x20 -> 0x21, stack_err=1; call_en+load_en+ret_en together with 1 entry -> the pop wins.
REQ-039 SHALL rerun REQ-036 without PC_SEQUENCER_CALL_STACK_EN -> call_en ignored, pc_out increments, stack_empty=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with increment, jump/branch and call/return support.
// The LIFO return stack is compiled in only when PC_SEQUENCER_CALL_STACK_EN is defined.
module pc_sequencer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter int               STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next,
    output logic             wrap,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_sel;
    logic [WIDTH-1:0] pc_inc;
    logic             wrap_reg;
    logic             wrap_next;

    assign pc_inc = pc_reg + WIDTH'(1);

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    wr_idx;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             err_reg;
    logic             err_next;

    assign full    = (count_reg == CW'(STACK_DEPTH));
    assign empty   = (count_reg == '0);
    assign top_idx = IW'(count_reg - CW'(1));
    assign wr_idx  = IW'(count_reg);

    // Priority chain: stall > ret > call > load > increment.
    // A failed pop still advances the PC but never counts as a wrap.
    always_comb begin
        pc_sel    = pc_inc;
        wrap_next = (pc_reg == '1);
        push      = 1'b0;
        pop       = 1'b0;
        err_next  = 1'b0;
        if (stall) begin
            pc_sel    = pc_reg;
            wrap_next = 1'b0;
        end else if (ret_en) begin
            wrap_next = 1'b0;
            if (!empty) begin
                pc_sel = stack_mem[top_idx];
                pop    = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (call_en) begin
            pc_sel    = load_addr;
            wrap_next = 1'b0;
            if (full) begin
                err_next = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (load_en) begin
            pc_sel    = load_addr;
            wrap_next = 1'b0;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push) begin
            count_next = count_reg + CW'(1);
        end else if (pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Entry storage is never reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_reg;
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = call_en ^ ret_en;

    always_comb begin
        pc_sel    = pc_inc;
        wrap_next = (pc_reg == '1);
        if (stall) begin
            pc_sel    = pc_reg;
            wrap_next = 1'b0;
        end else if (load_en) begin
            pc_sel    = load_addr;
            wrap_next = 1'b0;
        end
    end

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg   <= RESET_VEC;
            wrap_reg <= 1'b0;
        end else begin
            pc_reg   <= pc_sel;
            wrap_reg <= wrap_next;
        end
    end

    assign pc_out  = pc_reg;
    assign pc_next = rst ? RESET_VEC : pc_sel;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer; expectations follow PC_SEQUENCER_CALL_STACK_EN.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       stall;
    logic       load_en;
    logic [7:0] load_addr;
    logic       call_en;
    logic       ret_en;
    logic [7:0] pc_out;
    logic [7:0] pc_next;
    logic       wrap;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    pc_sequencer #(
        .WIDTH      (8),
        .RESET_VEC  (8'h10),
        .STACK_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .pc_out     (pc_out),
        .pc_next    (pc_next),
        .wrap       (wrap),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       stall;
        logic       ld;
        logic       call;
        logic       ret;
        logic [7:0] addr;
        logic [7:0] pc;
        logic       wrap;
        logic       full;
        logic       empty;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(string n, bit r, bit s, bit l, bit c, bit rt,
                                logic [7:0] a, logic [7:0] pc, bit w, bit f, bit e, bit err);
        vec_t v;
        v.name = n; v.rst = r; v.stall = s; v.ld = l; v.call = c; v.ret = rt;
        v.addr = a; v.pc = pc; v.wrap = w; v.full = f; v.empty = e; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    task automatic drive(bit r, bit s, bit l, bit c, bit rt, logic [7:0] a);
        rst = r; stall = s; load_en = l; call_en = c; ret_en = rt; load_addr = a;
    endtask

    initial begin
        logic [7:0] exp_pc;
        logic [7:0] prev_pc;
        int         wraps;

        drive(1, 0, 0, 0, 0, 8'h00);

        //  name          rst st ld ca re addr   pc                  wr full  empty err
        add("reset",       1, 0, 1, 0, 0, 8'h40, 8'h10,              0, 0,    1,    0);
        add("run_11",      0, 0, 0, 0, 0, 8'h00, 8'h11,              0, 0,    1,    0);
        add("run_12",      0, 0, 0, 0, 0, 8'h00, 8'h12,              0, 0,    1,    0);
        add("load_fe",     0, 0, 1, 0, 0, 8'hFE, 8'hFE,              0, 0,    1,    0);
        add("inc_ff",      0, 0, 0, 0, 0, 8'h00, 8'hFF,              0, 0,    1,    0);
        add("stall_ff",    0, 1, 0, 0, 0, 8'h00, 8'hFF,              0, 0,    1,    0);
        add("wrap_00",     0, 0, 0, 0, 0, 8'h00, 8'h00,              1, 0,    1,    0);
        add("post_wrap",   0, 0, 0, 0, 0, 8'h00, 8'h01,              0, 0,    1,    0);
        add("load_05",     0, 0, 1, 0, 0, 8'h05, 8'h05,              0, 0,    1,    0);
        add("call_80",     0, 0, 0, 1, 0, 8'h80, SE ? 8'h80 : 8'h06, 0, 0,    !SE,  0);
        add("run_81",      0, 0, 0, 0, 0, 8'h00, SE ? 8'h81 : 8'h07, 0, 0,    !SE,  0);
        add("run_82",      0, 0, 0, 0, 0, 8'h00, SE ? 8'h82 : 8'h08, 0, 0,    !SE,  0);
        add("ret_06",      0, 0, 0, 0, 1, 8'h00, SE ? 8'h06 : 8'h09, 0, 0,    1,    0);
        add("stall_all",   0, 1, 1, 1, 1, 8'hAA, SE ? 8'h06 : 8'h09, 0, 0,    1,    0);
        add("load_10",     0, 0, 1, 0, 0, 8'h10, 8'h10,              0, 0,    1,    0);
        add("call1",       0, 0, 0, 1, 0, 8'h20, SE ? 8'h20 : 8'h11, 0, 0,    !SE,  0);
        add("call2",       0, 0, 0, 1, 0, 8'h30, SE ? 8'h30 : 8'h12, 0, 0,    !SE,  0);
        add("call3",       0, 0, 0, 1, 0, 8'h40, SE ? 8'h40 : 8'h13, 0, 0,    !SE,  0);
        add("call4",       0, 0, 0, 1, 0, 8'h50, SE ? 8'h50 : 8'h14, 0, SE,   !SE,  0);
        add("call5_ovf",   0, 0, 0, 1, 0, 8'h60, SE ? 8'h60 : 8'h15, 0, SE,   !SE,  SE);
        add("run_61",      0, 0, 0, 0, 0, 8'h00, SE ? 8'h61 : 8'h16, 0, SE,   !SE,  0);
        add("ret_41",      0, 0, 0, 0, 1, 8'h00, SE ? 8'h41 : 8'h17, 0, 0,    !SE,  0);
        add("ret_31",      0, 0, 0, 0, 1, 8'h00, SE ? 8'h31 : 8'h18, 0, 0,    !SE,  0);
        add("ret_21",      0, 0, 0, 0, 1, 8'h00, SE ? 8'h21 : 8'h19, 0, 0,    !SE,  0);
        add("ret_11",      0, 0, 0, 0, 1, 8'h00, SE ? 8'h11 : 8'h1A, 0, 0,    1,    0);
        add("load_20",     0, 0, 1, 0, 0, 8'h20, 8'h20,              0, 0,    1,    0);
        add("ret_empty",   0, 0, 0, 0, 1, 8'h00, 8'h21,              0, 0,    1,    SE);
        add("call_70",     0, 0, 0, 1, 0, 8'h70, SE ? 8'h70 : 8'h22, 0, 0,    !SE,  0);
        add("all_three",   0, 0, 1, 1, 1, 8'h90, SE ? 8'h22 : 8'h90, 0, 0,    1,    0);
        add("call_50",     0, 0, 0, 1, 0, 8'h50, SE ? 8'h50 : 8'h91, 0, 0,    !SE,  0);
        add("rst_mid",     1, 1, 0, 0, 1, 8'h00, 8'h10,              0, 0,    1,    0);
        add("stall_ret",   0, 1, 0, 0, 1, 8'h00, 8'h10,              0, 0,    1,    0);
        add("ret_post_rst",0, 0, 0, 0, 1, 8'h00, 8'h11,              0, 0,    1,    SE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].ld, vecs[i].call, vecs[i].ret, vecs[i].addr);
            #1;
            chk({vecs[i].name, ".pc_next"}, pc_next, vecs[i].pc);
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".pc_out"}, pc_out, vecs[i].pc);
            chk({vecs[i].name, ".wrap"}, {7'd0, wrap}, {7'd0, vecs[i].wrap});
            chk({vecs[i].name, ".full"}, {7'd0, stack_full}, {7'd0, vecs[i].full});
            chk({vecs[i].name, ".empty"}, {7'd0, stack_empty}, {7'd0, vecs[i].empty});
            chk({vecs[i].name, ".err"}, {7'd0, stack_err}, {7'd0, vecs[i].err});
            $display("vec %0d %s pc_out=%h wrap=%b full=%b empty=%b err=%b",
                     i, vecs[i].name, pc_out, wrap, stack_full, stack_empty, stack_err);
        end

        // Free run over one full period: exactly one wrap pulse, on the FF->00 step.
        drive(0, 0, 0, 0, 0, 8'h00);
        exp_pc = 8'h11;
        wraps  = 0;
        for (int i = 0; i < 256; i++) begin
            prev_pc = exp_pc;
            exp_pc  = exp_pc + 8'd1;
            @(posedge clk);
            #1;
            chk("freerun.pc_out", pc_out, exp_pc);
            chk("freerun.wrap", {7'd0, wrap}, {7'd0, (prev_pc == 8'hFF)});
            if (wrap) wraps++;
        end
        chk("freerun.wrap_count", 8'(wraps), 8'd1);
        $display("freerun done pc_out=%h wraps=%0d", pc_out, wraps);

        // A multi-cycle stall at FF holds the PC and suppresses wrap until released.
        drive(0, 0, 1, 0, 0, 8'hFF);
        @(posedge clk);
        #1;
        chk("hold.load_ff", pc_out, 8'hFF);
        drive(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.stall_next", pc_next, 8'hFF);
            @(posedge clk);
            #1;
            chk("hold.stall_pc", pc_out, 8'hFF);
            chk("hold.stall_wrap", {7'd0, wrap}, 8'd0);
        end
        drive(0, 0, 0, 0, 0, 8'h00);
        #1;
        chk("hold.release_next", pc_next, 8'h00);
        @(posedge clk);
        #1;
        chk("hold.release_pc", pc_out, 8'h00);
        chk("hold.release_wrap", {7'd0, wrap}, 8'd1);
        @(posedge clk);
        #1;
        chk("hold.after_pc", pc_out, 8'h01);
        chk("hold.after_wrap", {7'd0, wrap}, 8'd0);
        $display("stall-at-ff sequence done pc_out=%h", pc_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
